// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 VGA timing constants and the coordinate type shared by
// the raster generator and its axis counters.
package vga_timing_pkg;

    localparam int unsigned COORD_W     = 10;
    localparam int unsigned COORD_LIMIT = 1 << COORD_W;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FP      = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BP      = 48;
    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FP      = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BP      = 33;

    localparam int unsigned DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int unsigned DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef logic [COORD_W-1:0] coord_t;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping 0..TOTAL-1 counter plus sync-window and visible
// flags decoded from the count it will hold after this edge.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL      = DEF_H_TOTAL,
    parameter int unsigned VISIBLE    = DEF_H_VISIBLE,
    parameter int unsigned SYNC_START = DEF_H_VISIBLE + DEF_H_FP,
    parameter int unsigned SYNC_END   = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   step_i,
    output coord_t cnt_next_o,
    output coord_t cnt_o,
    output logic   wrap_o,
    output logic   in_sync_o,
    output logic   visible_o
);

    // One extra bit so a window edge equal to 2**COORD_W still compares correctly.
    localparam logic [COORD_W:0] SYNC_LO = (COORD_W+1)'(SYNC_START);
    localparam logic [COORD_W:0] SYNC_HI = (COORD_W+1)'(SYNC_END);
    localparam logic [COORD_W:0] VIS_HI  = (COORD_W+1)'(VISIBLE);
    localparam coord_t           LAST    = COORD_W'(TOTAL - 1);

    coord_t           cnt_q;
    coord_t           cnt_d;
    logic [COORD_W:0] cnt_ext;

    assign wrap_o = (cnt_q == LAST);

    // NOTE: default assignment first so every path writes cnt_d and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (step_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + COORD_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= LAST;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_ext    = {1'b0, cnt_d};
    assign cnt_next_o = cnt_d;
    assign cnt_o      = cnt_q;
    assign in_sync_o  = (cnt_ext >= SYNC_LO) && (cnt_ext < SYNC_HI);
    assign visible_o  = (cnt_ext < VIS_HI);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-tick driven x/y counters with registered
// sync, blanking and line/frame start pulses aligned to the coordinates.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE   = DEF_H_VISIBLE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_VISIBLE   = DEF_V_VISIBLE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter logic        SYNC_ACTIVE = 1'b0
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   pix_en,
    output logic   hsync,
    output logic   vsync,
    output logic   video_on,
    output coord_t pixel_x,
    output coord_t pixel_y,
    output logic   line_start,
    output logic   frame_start
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > COORD_LIMIT || V_TOTAL > COORD_LIMIT) begin : g_bad_timing
        $error("vga_sync_gen: line or frame total exceeds the coordinate range");
    end

    coord_t h_next, v_next;
    logic   h_wrap, v_wrap_unused;
    logic   h_sync_win, v_sync_win, h_vis, v_vis;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .VISIBLE    (H_VISIBLE),
        .SYNC_START (H_VISIBLE + H_FP),
        .SYNC_END   (H_VISIBLE + H_FP + H_SYNC)
    ) u_h_axis (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_i     (pix_en),
        .cnt_next_o (h_next),
        .cnt_o      (pixel_x),
        .wrap_o     (h_wrap),
        .in_sync_o  (h_sync_win),
        .visible_o  (h_vis)
    );

    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .VISIBLE    (V_VISIBLE),
        .SYNC_START (V_VISIBLE + V_FP),
        .SYNC_END   (V_VISIBLE + V_FP + V_SYNC)
    ) u_v_axis (
        .clk        (clk),
        .rst_n      (rst_n),
        .step_i     (pix_en && h_wrap),
        .cnt_next_o (v_next),
        .cnt_o      (pixel_y),
        .wrap_o     (v_wrap_unused),
        .in_sync_o  (v_sync_win),
        .visible_o  (v_vis)
    );

    logic hsync_q, hsync_d;
    logic vsync_q, vsync_d;
    logic video_on_q, video_on_d;
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;

    // Levels hold between ticks; the start pulses last only for the tick's clk.
    always_comb begin
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        video_on_d    = video_on_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (pix_en) begin
            hsync_d       = h_sync_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync_d       = v_sync_win ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            video_on_d    = h_vis && v_vis;
            line_start_d  = (h_next == '0);
            frame_start_d = (h_next == '0) && (v_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hsync_q       <= ~SYNC_ACTIVE;
            vsync_q       <= ~SYNC_ACTIVE;
            video_on_q    <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default build, a shrunken-timing build for
// whole-frame behaviour, and a positive-sync build, all on one stimulus.
module tb_vga_sync_gen;
    import vga_timing_pkg::*;

    typedef struct {
        int hv, hfp, hs, hbp, vv, vfp, vs, vbp;
        bit act;
    } timing_t;

    typedef struct {
        int ticks;
        int x, y;
        bit hs, vs, vid, ls, fs;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_en = 1'b0;
    always #5 clk = ~clk;

    logic [2:0][COORD_W-1:0] px, py;
    logic [2:0] hs, vs, vid, ls, fs;

    int n_vec = 0;
    int n_bad = 0;

    timing_t cfg[3];
    int mx[3], my[3];
    bit mh[3], mv[3], mvid[3], mls[3], mfs[3];

    vga_sync_gen u_dflt (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .hsync(hs[0]), .vsync(vs[0]), .video_on(vid[0]),
        .pixel_x(px[0]), .pixel_y(py[0]),
        .line_start(ls[0]), .frame_start(fs[0])
    );

    vga_sync_gen #(
        .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_VISIBLE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .hsync(hs[1]), .vsync(vs[1]), .video_on(vid[1]),
        .pixel_x(px[1]), .pixel_y(py[1]),
        .line_start(ls[1]), .frame_start(fs[1])
    );

    vga_sync_gen #(.SYNC_ACTIVE(1'b1)) u_pos (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .hsync(hs[2]), .vsync(vs[2]), .video_on(vid[2]),
        .pixel_x(px[2]), .pixel_y(py[2]),
        .line_start(ls[2]), .frame_start(fs[2])
    );

    function automatic int h_tot(input int i);
        return cfg[i].hv + cfg[i].hfp + cfg[i].hs + cfg[i].hbp;
    endfunction

    function automatic int v_tot(input int i);
        return cfg[i].vv + cfg[i].vfp + cfg[i].vs + cfg[i].vbp;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mx[i] = h_tot(i) - 1;
            my[i] = v_tot(i) - 1;
            mh[i] = !cfg[i].act;
            mv[i] = !cfg[i].act;
            mvid[i] = 1'b0;
            mls[i] = 1'b0;
            mfs[i] = 1'b0;
        end
    endtask

    task automatic model_tick();
        for (int i = 0; i < 3; i++) begin
            if (mx[i] == h_tot(i) - 1) begin
                mx[i] = 0;
                my[i] = (my[i] == v_tot(i) - 1) ? 0 : my[i] + 1;
            end else begin
                mx[i] = mx[i] + 1;
            end
            mh[i] = (mx[i] >= cfg[i].hv + cfg[i].hfp &&
                     mx[i] <  cfg[i].hv + cfg[i].hfp + cfg[i].hs) ? cfg[i].act : !cfg[i].act;
            mv[i] = (my[i] >= cfg[i].vv + cfg[i].vfp &&
                     my[i] <  cfg[i].vv + cfg[i].vfp + cfg[i].vs) ? cfg[i].act : !cfg[i].act;
            mvid[i] = (mx[i] < cfg[i].hv) && (my[i] < cfg[i].vv);
            mls[i] = (mx[i] == 0);
            mfs[i] = (mx[i] == 0) && (my[i] == 0);
        end
    endtask

    task automatic model_idle();
        for (int i = 0; i < 3; i++) begin
            mls[i] = 1'b0;
            mfs[i] = 1'b0;
        end
    endtask

    // Called at a negedge; drives pix_en for the next posedge and returns at the following negedge.
    task automatic step(input bit en);
        pix_en = en;
        @(negedge clk);
        if (!rst_n) model_reset();
        else if (en) model_tick();
        else model_idle();
    endtask

    task automatic check_model(input int i, input string tag);
        check({tag, " pixel_x"},     int'(px[i]),  mx[i]);
        check({tag, " pixel_y"},     int'(py[i]),  my[i]);
        check({tag, " hsync"},       int'(hs[i]),  int'(mh[i]));
        check({tag, " vsync"},       int'(vs[i]),  int'(mv[i]));
        check({tag, " video_on"},    int'(vid[i]), int'(mvid[i]));
        check({tag, " line_start"},  int'(ls[i]),  int'(mls[i]));
        check({tag, " frame_start"}, int'(fs[i]),  int'(mfs[i]));
    endtask

    task automatic check_vec(input int i, input string tag, input vec_t e, input bit inv);
        check({tag, " pixel_x"},     int'(px[i]),  e.x);
        check({tag, " pixel_y"},     int'(py[i]),  e.y);
        check({tag, " hsync"},       int'(hs[i]),  int'(e.hs ^ inv));
        check({tag, " vsync"},       int'(vs[i]),  int'(e.vs ^ inv));
        check({tag, " video_on"},    int'(vid[i]), int'(e.vid));
        check({tag, " line_start"},  int'(ls[i]),  int'(e.ls));
        check({tag, " frame_start"}, int'(fs[i]),  int'(e.fs));
    endtask

    initial begin
        vec_t tbl[11];
        int h_act_cnt, vid_cnt, pulse_cnt;
        int tick_no, last_fs, f_vs, f_hs, f_vid;

        cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
        cfg[1] = '{8, 2, 3, 2, 6, 2, 2, 3, 1'b0};
        cfg[2] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b1};

        // Walk along line 0 of the default build with one tick every 2nd clk.
        tbl[0]  = '{0,   799, 524, 1, 1, 0, 0, 0};
        tbl[1]  = '{1,   0,   0,   1, 1, 1, 1, 1};
        tbl[2]  = '{639, 639, 0,   1, 1, 1, 0, 0};
        tbl[3]  = '{1,   640, 0,   1, 1, 0, 0, 0};
        tbl[4]  = '{15,  655, 0,   1, 1, 0, 0, 0};
        tbl[5]  = '{1,   656, 0,   0, 1, 0, 0, 0};
        tbl[6]  = '{95,  751, 0,   0, 1, 0, 0, 0};
        tbl[7]  = '{1,   752, 0,   1, 1, 0, 0, 0};
        tbl[8]  = '{47,  799, 0,   1, 1, 0, 0, 0};
        tbl[9]  = '{1,   0,   1,   1, 1, 1, 1, 0};
        tbl[10] = '{1,   1,   1,   1, 1, 1, 0, 0};

        @(negedge clk);
        rst_n = 1'b0;
        step(0);
        step(1);
        rst_n = 1'b1;
        step(0);

        h_act_cnt = 0;
        vid_cnt = 0;
        for (int v = 0; v < 11; v++) begin
            for (int k = 0; k < tbl[v].ticks; k++) begin
                step(0);
                step(1);
                check_model(1, "small walk");
                if (py[0] == 0 && hs[0] == 1'b0) h_act_cnt++;
                if (py[0] == 0 && vid[0] == 1'b1) vid_cnt++;
            end
            check_vec(0, $sformatf("dflt vec%0d", v), tbl[v], 1'b0);
            check_vec(2, $sformatf("pos vec%0d", v), tbl[v], 1'b1);
        end
        check("line0 hsync-active ticks", h_act_cnt, 96);
        check("line0 video_on ticks", vid_cnt, 640);

        // Line-start pulse lasts one clk, then a 50-clk pix_en gap freezes everything.
        for (int k = 0; k < 20 && !(px[1] == 0 && ls[1] == 1'b1); k++) step(1);
        check("small line_start at wrap", int'(ls[1]), 1);
        step(0);
        check("small line_start one clk", int'(ls[1]), 0);
        pulse_cnt = 0;
        for (int k = 0; k < 50; k++) begin
            step(0);
            if (ls != 3'b000 || fs != 3'b000) pulse_cnt++;
            check_model(0, "hold dflt");
            check_model(1, "hold small");
            check_model(2, "hold pos");
        end
        check("pulses during hold", pulse_cnt, 0);

        // Back-to-back ticks across several small frames; frame period is 15*13.
        tick_no = 0;
        last_fs = -1;
        f_vs = 0;
        f_hs = 0;
        f_vid = 0;
        for (int k = 0; k < 4 * 195; k++) begin
            step(1);
            tick_no++;
            check_model(0, "b2b dflt");
            check_model(1, "b2b small");
            check_model(2, "b2b pos");
            if (fs[1] == 1'b1) begin
                if (last_fs >= 0) begin
                    check("small frame period", tick_no - last_fs, 195);
                    check("small vsync-active ticks/frame", f_vs, 30);
                    check("small hsync-active ticks/frame", f_hs, 39);
                    check("small video_on ticks/frame", f_vid, 48);
                end
                last_fs = tick_no;
                f_vs = 0;
                f_hs = 0;
                f_vid = 0;
            end
            if (vs[1] == 1'b0) f_vs++;
            if (hs[1] == 1'b0) f_hs++;
            if (vid[1] == 1'b1) f_vid++;
        end
        check("small frame_starts seen", int'(last_fs > 0), 1);

        // Reset mid-frame (with pix_en high) returns to the reset state.
        for (int k = 0; k < 400 && !(px[1] == 5 && py[1] == 3); k++) step(1);
        check("small reached x", int'(px[1]), 5);
        check("small reached y", int'(py[1]), 3);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check_vec(0, "rst dflt", '{0, 799, 524, 1, 1, 0, 0, 0}, 1'b0);
        check_vec(1, "rst small", '{0, 14, 12, 1, 1, 0, 0, 0}, 1'b0);
        check_vec(2, "rst pos", '{0, 799, 524, 1, 1, 0, 0, 0}, 1'b1);
        step(1);
        check_vec(0, "post-rst dflt", '{1, 0, 0, 1, 1, 1, 1, 1}, 1'b0);
        check_vec(1, "post-rst small", '{1, 0, 0, 1, 1, 1, 1, 1}, 1'b0);
        check_vec(2, "post-rst pos", '{1, 0, 0, 1, 1, 1, 1, 1}, 1'b1);
        step(0);
        check("post-rst frame_start one clk", int'(fs), 0);
        check("post-rst line_start one clk", int'(ls), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
